systolic_ctrl: RTL and testbench

Sequencing controller for the SIZE×SIZE systolic matrix-multiply datapath.
- Accepts SIZE input beats, each an x column plus a w row, through a val/rdy handshake, and writes them into the x and w FIFOs.
- Issues the diagonally skewed FIFO reads and the `mac_en` window, then streams all SIZE² results out row-major through a val/rdy handshake.
- It sits between the accelerator's stream interface and the datapath. It drives only control; data wires connect directly at the top level.

---
 rtl/systolic_ctrl_pkg.sv | 16 +
 rtl/systolic_skew_gen.sv | 19 +
 rtl/systolic_ctrl.sv | 132 +++++++++++++
 tb/tb_systolic_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencing controller.
package systolic_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } systolic_ctrl_state_t;

    // Cycles needed for the last skewed operand pair to reach the far PE.
    function automatic int compute_len(input int size);
        return 3 * size - 1;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Diagonal read-enable mask: lane i pops during the SIZE cycles starting at k = i.
module systolic_skew_gen #(
    parameter int SIZE = 4
) (
    input  logic [$clog2(3*SIZE)-1:0] k,
    input  logic                      active,
    output logic [SIZE-1:0]           ren
);

    localparam int KW = $clog2(3 * SIZE);

    always_comb begin
        ren = '0;
        for (int i = 0; i < SIZE; i++) begin
            ren[i] = active && (k >= KW'(i)) && (k < KW'(i + SIZE));
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencing controller for the SIZE x SIZE systolic matrix-multiply datapath.
// Optional busy-cycle counter port perf_cycles is enabled by SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic                    acc_clr,
    output logic                    mac_en,
    output logic [SIZE-1:0]         x_fifo_wen,
    output logic [SIZE-1:0]         w_fifo_wen,
    output logic [SIZE-1:0]         x_fifo_ren,
    output logic [SIZE-1:0]         w_fifo_ren,
    input  logic [SIZE-1:0]         x_fifo_full,
    input  logic [SIZE-1:0]         w_fifo_full,
    input  logic [SIZE-1:0]         x_fifo_empty,
    input  logic [SIZE-1:0]         w_fifo_empty,
    output logic [$clog2(SIZE)-1:0] out_rsel,
    output logic [$clog2(SIZE)-1:0] out_csel,
    output logic                    busy
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int SW   = $clog2(SIZE);
    localparam int KW   = $clog2(3 * SIZE);
    localparam int CLEN = compute_len(SIZE);

    systolic_ctrl_state_t state, state_nxt;

    logic [SW-1:0]   load_cnt;
    logic [KW-1:0]   k;
    logic [SW-1:0]   rsel, csel;
    logic [SIZE-1:0] ren_mask;
    logic            in_hs, out_hs;
    logic            last_load, last_k, last_out;

    // Empty flags are not consulted: a scheduled pop on an empty FIFO is an upstream protocol error.
    logic            unused_empty;
    assign unused_empty = ^{x_fifo_empty, w_fifo_empty};

    assign in_hs     = in_val & in_rdy;
    assign out_hs    = out_val & out_rdy;
    assign last_load = in_hs && (load_cnt == SW'(SIZE - 1));
    assign last_k    = (k == KW'(CLEN - 1));
    assign last_out  = out_hs && (rsel == SW'(SIZE - 1)) && (csel == SW'(SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = LOAD;
            LOAD:    if (last_load) state_nxt = COMPUTE;
            COMPUTE: if (last_k)    state_nxt = OUTPUT;
            OUTPUT:  if (last_out)  state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        acc_clr    = (state == CLEAR);
        mac_en     = (state == COMPUTE);
        out_val    = (state == OUTPUT);
        busy       = (state != LOAD);
        in_rdy     = (state == LOAD) && !(|x_fifo_full) && !(|w_fifo_full);
        x_fifo_wen = {SIZE{in_val & in_rdy}};
        w_fifo_wen = {SIZE{in_val & in_rdy}};
        x_fifo_ren = ren_mask;
        w_fifo_ren = ren_mask;
        out_rsel   = rsel;
        out_csel   = csel;
    end

    always_ff @(posedge clk) begin
        if (rst || state == CLEAR) begin
            load_cnt <= '0;
            k        <= '0;
            rsel     <= '0;
            csel     <= '0;
        end else begin
            if (state == LOAD && in_hs) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (state == COMPUTE) begin
                k <= k + 1'b1;
            end
            // Row-major walk over the result array.
            if (out_hs) begin
                if (csel == SW'(SIZE - 1)) begin
                    csel <= '0;
                    rsel <= rsel + 1'b1;
                end else begin
                    csel <= csel + 1'b1;
                end
            end
        end
    end

    systolic_skew_gen #(
        .SIZE(SIZE)
    ) u_skew (
        .k      (k),
        .active (state == COMPUTE),
        .ren    (ren_mask)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != '1) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: random jobs, FIFO occupancy model, directed corner cases.
module tb_systolic_ctrl;

    localparam int SIZE  = 4;
    localparam int SW    = $clog2(SIZE);
    localparam int DEPTH = 4 * SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_val, in_rdy, out_val, out_rdy;
    logic            acc_clr, mac_en, busy;
    logic [SIZE-1:0] x_fifo_wen, w_fifo_wen, x_fifo_ren, w_fifo_ren;
    logic [SIZE-1:0] x_fifo_full, w_fifo_full, x_fifo_empty, w_fifo_empty;
    logic [SIZE-1:0] x_full_force;
    logic [SW-1:0]   out_rsel, out_csel;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
    int              perf_base;
`endif

    typedef struct {
        int r;
        int c;
    } sel_t;

    sel_t exp_q[$];
    sel_t got;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    logic prev_out_val = 1'b0;
    int   xcnt[SIZE] = '{default: 0};
    int   wcnt[SIZE] = '{default: 0};
    int   win_len = 0;
    int   pops[SIZE];
    int   first_pop[SIZE];
    int   last_pop[SIZE];

    systolic_ctrl #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .acc_clr      (acc_clr),
        .mac_en       (mac_en),
        .x_fifo_wen   (x_fifo_wen),
        .w_fifo_wen   (w_fifo_wen),
        .x_fifo_ren   (x_fifo_ren),
        .w_fifo_ren   (w_fifo_ren),
        .x_fifo_full  (x_fifo_full),
        .w_fifo_full  (w_fifo_full),
        .x_fifo_empty (x_fifo_empty),
        .w_fifo_empty (w_fifo_empty),
        .out_rsel     (out_rsel),
        .out_csel     (out_csel),
        .busy         (busy)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        x_fifo_full  = '0;
        w_fifo_full  = '0;
        x_fifo_empty = '0;
        w_fifo_empty = '0;
        for (int i = 0; i < SIZE; i++) begin
            x_fifo_full[i]  = (xcnt[i] >= DEPTH) || x_full_force[i];
            w_fifo_full[i]  = (wcnt[i] >= DEPTH);
            x_fifo_empty[i] = (xcnt[i] == 0);
            w_fifo_empty[i] = (wcnt[i] == 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_win();
        win_len = 0;
        for (int i = 0; i < SIZE; i++) begin
            pops[i]      = 0;
            first_pop[i] = -1;
            last_pop[i]  = -1;
        end
    endtask

    // Monitor: FIFO occupancy, pop window shape, output scoreboard, latency.
    always @(negedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            if (!rst && x_fifo_ren[i]) check("x_pop_nonempty", (xcnt[i] > 0), 1);
            if (!rst && w_fifo_ren[i]) check("w_pop_nonempty", (wcnt[i] > 0), 1);
            xcnt[i] = xcnt[i] + int'(x_fifo_wen[i]) - int'(x_fifo_ren[i]);
            wcnt[i] = wcnt[i] + int'(w_fifo_wen[i]) - int'(w_fifo_ren[i]);
            if (xcnt[i] < 0) xcnt[i] = 0;
            if (wcnt[i] < 0) wcnt[i] = 0;
        end
        if (rst) begin
            clear_win();
            prev_out_val = 1'b0;
        end else begin
            if (in_val && in_rdy) begin
                check("wen_x_on_hs", x_fifo_wen, {SIZE{1'b1}});
                check("wen_w_on_hs", w_fifo_wen, {SIZE{1'b1}});
                last_hs_cyc = cyc;
            end else begin
                check("wen_idle", x_fifo_wen | w_fifo_wen, 0);
            end
            if (mac_en) begin
                check("ren_x_eq_w", w_fifo_ren, x_fifo_ren);
                check("out_val_in_compute", out_val, 0);
                for (int i = 0; i < SIZE; i++) begin
                    if (x_fifo_ren[i]) begin
                        pops[i]++;
                        if (first_pop[i] < 0) first_pop[i] = win_len;
                        last_pop[i] = win_len;
                    end
                end
                win_len++;
            end else begin
                check("ren_idle", x_fifo_ren | w_fifo_ren, 0);
                if (win_len > 0) begin
                    check("mac_en_len", win_len, 3 * SIZE - 1);
                    for (int i = 0; i < SIZE; i++) begin
                        check("lane_pops", pops[i], SIZE);
                        check("lane_first_pop", first_pop[i], i);
                        check("lane_contig", last_pop[i] - first_pop[i], SIZE - 1);
                    end
                    clear_win();
                end
            end
            if (out_val && !prev_out_val) check("first_out_latency", cyc - last_hs_cyc, 3 * SIZE);
            prev_out_val = out_val;
            if (out_val && out_rdy) begin
                check("mac_off_in_output", mac_en, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 0, 1);
                end else begin
                    got = exp_q.pop_front();
                    check("rsel", out_rsel, got.r);
                    check("csel", out_csel, got.c);
                end
            end
        end
    end

    task automatic push_job();
        sel_t s;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                s.r = r;
                s.c = c;
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic load_beats(input bit rand_in, input bit stall);
        int loaded = 0;
        int budget = 0;
        bit stalled = 1'b0;
        while (loaded < SIZE && budget < 200) begin
            if (stall && !stalled && loaded == 1) begin
                stalled = 1'b1;
                x_full_force    = '0;
                x_full_force[2] = 1'b1;
                in_val = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_rdy", in_rdy, 0);
                    check("stall_wen", x_fifo_wen | w_fifo_wen, 0);
                    @(posedge clk); #1;
                end
                x_full_force = '0;
            end
            in_val = rand_in ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (in_val && in_rdy) loaded++;
            @(posedge clk); #1;
            budget++;
        end
        in_val = 1'b0;
        if (loaded < SIZE) check("load_timeout", loaded, SIZE);
    endtask

    task automatic drain(input bit rand_out, input bit bp);
        int budget = 0;
        bit bp_done = 1'b0;
        while (exp_q.size() > 0 && budget < 400) begin
            if (bp && !bp_done && out_val && exp_q[0].r == 1 && exp_q[0].c == 2) begin
                bp_done = 1'b1;
                out_rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_rsel", out_rsel, 1);
                    check("bp_csel", out_csel, 2);
                    check("bp_out_val", out_val, 1);
                    @(posedge clk); #1;
                end
            end
            out_rdy = rand_out ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        out_rdy = 1'b0;
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        if (bp) check("bp_reached", bp_done, 1);
        @(negedge clk);
        check("acc_clr_pulse", acc_clr, 1);
        check("clear_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("load_acc_clr_low", acc_clr, 0);
        check("load_busy_low", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input bit rand_in, input bit rand_out, input bit bp, input bit stall);
        push_job();
        load_beats(rand_in, stall);
        drain(rand_out, bp);
    endtask

    task automatic reset_mid_compute();
        int k = -1;
        int budget = 0;
        load_beats(1'b0, 1'b0);
        in_val = 1'b1;
        while (k < 5 && budget < 50) begin
            @(negedge clk);
            check("compute_in_rdy", in_rdy, 0);
            if (mac_en) k++;
            budget++;
        end
        if (k < 5) check("compute_timeout", k, 5);
        #1;
        rst    = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        check("midrst_acc_clr", acc_clr, 1);
        check("midrst_mac_en", mac_en, 0);
        check("midrst_ren", x_fifo_ren | w_fifo_ren, 0);
        check("midrst_out_val", out_val, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_val       = 1'b0;
        out_rdy      = 1'b0;
        x_full_force = '0;

        @(posedge clk); #1;
        @(negedge clk);
        check("rst_acc_clr", acc_clr, 1);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_out_val", out_val, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_busy", busy, 1);
        check("rst_sel", {out_rsel, out_csel}, 0);
        check("rst_ren", x_fifo_ren | w_fifo_ren, 0);
        check("rst_wen", x_fifo_wen | w_fifo_wen, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("rst_perf", perf_cycles, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_clear", acc_clr, 1);
        check("post_rst_in_rdy", in_rdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("load_in_rdy", in_rdy, 1);
        check("load_busy", busy, 0);
        @(posedge clk); #1;
`ifdef SYSTOLIC_CTRL_PERF_EN
        perf_base = perf_cycles;
`endif

        run_job(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("perf_one_job", perf_cycles - perf_base, 28);
`endif
        run_job(1'b0, 1'b0, 1'b1, 1'b0);
        reset_mid_compute();
        run_job(1'b1, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            run_job(1'b1, 1'b1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
